// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester arbiter that shares one combinational ALU.
// A single registered issue stage drives the ALU. Each result lands in a
// per-requester response buffer with a valid/ready handshake.
module alu_share_arb #(
    parameter bit          FAIR  = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic [1:0]            rq_valid,
    output logic [1:0]            rq_ready,
    input  logic [1:0][4:0]       rq_opcode,
    input  logic [1:0][31:0]      rq_x,
    input  logic [1:0][31:0]      rq_y,
    // response side
    output logic [1:0]            rs_valid,
    input  logic [1:0]            rs_ready,
    output logic [1:0][31:0]      rs_result,
    output logic [1:0]            rs_overflow,
    output logic [1:0]            rs_y_zero,
    // shared ALU
    output logic [4:0]            alu_opcode,
    output logic [31:0]           alu_op_x,
    output logic [31:0]           alu_op_y,
    input  logic [31:0]           alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_op_y_zero,
    // status
    output logic                  busy,
    output logic [CNT_W-1:0]      contention_cnt
);

    localparam int unsigned NPORT = 2;

    logic       iss_valid;
    logic       iss_owner;
    logic       rr_ptr;
    logic [1:0] inflight;
    logic [1:0] free;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       contend;

    // Eligibility and grant; a draining response buffer counts as free
    always_comb begin
        inflight = {iss_valid & iss_owner, iss_valid & ~iss_owner};
        free     = ~inflight & (~rs_valid | rs_ready);
        elig     = rq_valid & free;
        contend  = &elig;
        grant    = 2'b00;
        if (!rst) begin
            if (contend) begin
                grant = (FAIR && rr_ptr) ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    assign rq_ready = grant;
    assign busy     = iss_valid | (|rs_valid);

    // Issue stage: latch the winner's operands; hold ALU inputs when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid  <= 1'b0;
            iss_owner  <= 1'b0;
            alu_opcode <= 5'd0;
            alu_op_x   <= 32'd0;
            alu_op_y   <= 32'd0;
        end else begin
            iss_valid <= |grant;
            if (|grant) begin
                iss_owner  <= grant[1];
                alu_opcode <= grant[1] ? rq_opcode[1] : rq_opcode[0];
                alu_op_x   <= grant[1] ? rq_x[1]      : rq_x[0];
                alu_op_y   <= grant[1] ? rq_y[1]      : rq_y[0];
            end
        end
    end

    // Round-robin pointer advances only on contended grants
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (FAIR && contend) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Response buffers: a capture beats a same-edge handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_valid    <= 2'b00;
            rs_result   <= '0;
            rs_overflow <= 2'b00;
            rs_y_zero   <= 2'b00;
        end else begin
            for (int i = 0; i < int'(NPORT); i++) begin
                if (inflight[i]) begin
                    rs_valid[i]    <= 1'b1;
                    rs_result[i]   <= alu_result;
                    rs_overflow[i] <= alu_overflow;
                    rs_y_zero[i]   <= alu_op_y_zero;
                end else if (rs_ready[i]) begin
                    rs_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of cycles where both ports were eligible
    always_ff @(posedge clk) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (contend && (contention_cnt != '1)) begin
            contention_cnt <= contention_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: two instances (round-robin, and fixed priority with a
// narrow counter) driven by random requesters, with a transaction-level
// reference model and a per-port response scoreboard.
module tb_alu_share_arb;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        yz;
        int unsigned exp_cyc;
        bit          seen;
    } sb_t;

    localparam int M_IDLE = 0;
    localparam int M_CONT = 1;
    localparam int M_RAND = 2;
    localparam int M_BP   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       rq_valid    [2];
    logic [1:0]       rq_ready    [2];
    logic [1:0][4:0]  rq_opcode   [2];
    logic [1:0][31:0] rq_x        [2];
    logic [1:0][31:0] rq_y        [2];
    logic [1:0]       rs_valid    [2];
    logic [1:0]       rs_ready    [2];
    logic [1:0][31:0] rs_result   [2];
    logic [1:0]       rs_overflow [2];
    logic [1:0]       rs_y_zero   [2];
    logic [4:0]       alu_opcode  [2];
    logic [31:0]      alu_op_x    [2];
    logic [31:0]      alu_op_y    [2];
    logic [31:0]      alu_result  [2];
    logic             alu_overflow[2];
    logic             alu_op_y_zero[2];
    logic             busy        [2];
    logic [15:0]      cnt_a;
    logic [3:0]       cnt_b;

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          mode = M_IDLE;

    // requester hold state and reference model state, per instance and port
    bit          hv   [2][2];
    logic [4:0]  h_op [2][2];
    logic [31:0] h_x  [2][2];
    logic [31:0] h_y  [2][2];
    bit          infl [2][2];
    bit          rsv  [2][2];
    bit          ptr  [2];
    int unsigned cnt_m[2];
    sb_t         sq   [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural MIPS-style ALU: {y_zero, overflow, result}
    function automatic logic [33:0] ref_alu(input logic [4:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [31:0] r;
        logic        ov;
        ov = 1'b0;
        case (op)
            5'd0: begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
            5'd1: begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
            5'd2: r = x & y;
            5'd3: r = x | y;
            5'd4: r = x ^ y;
            5'd5: r = ~(x | y);
            5'd6: r = y << x[4:0];
            5'd7: r = y >> x[4:0];
            default: r = 32'hDEAD_0000 | {27'd0, op};
        endcase
        return {(y == 32'd0), ov, r};
    endfunction

    always_comb begin
        {alu_op_y_zero[0], alu_overflow[0], alu_result[0]} = ref_alu(alu_opcode[0], alu_op_x[0], alu_op_y[0]);
        {alu_op_y_zero[1], alu_overflow[1], alu_result[1]} = ref_alu(alu_opcode[1], alu_op_x[1], alu_op_y[1]);
    end

    alu_share_arb #(.FAIR(1'b1), .CNT_W(16)) dut_rr (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid[0]), .rq_ready(rq_ready[0]), .rq_opcode(rq_opcode[0]),
        .rq_x(rq_x[0]), .rq_y(rq_y[0]),
        .rs_valid(rs_valid[0]), .rs_ready(rs_ready[0]), .rs_result(rs_result[0]),
        .rs_overflow(rs_overflow[0]), .rs_y_zero(rs_y_zero[0]),
        .alu_opcode(alu_opcode[0]), .alu_op_x(alu_op_x[0]), .alu_op_y(alu_op_y[0]),
        .alu_result(alu_result[0]), .alu_overflow(alu_overflow[0]),
        .alu_op_y_zero(alu_op_y_zero[0]),
        .busy(busy[0]), .contention_cnt(cnt_a)
    );

    alu_share_arb #(.FAIR(1'b0), .CNT_W(4)) dut_fp (
        .clk(clk), .rst(rst),
        .rq_valid(rq_valid[1]), .rq_ready(rq_ready[1]), .rq_opcode(rq_opcode[1]),
        .rq_x(rq_x[1]), .rq_y(rq_y[1]),
        .rs_valid(rs_valid[1]), .rs_ready(rs_ready[1]), .rs_result(rs_result[1]),
        .rs_overflow(rs_overflow[1]), .rs_y_zero(rs_y_zero[1]),
        .alu_opcode(alu_opcode[1]), .alu_op_x(alu_op_x[1]), .alu_op_y(alu_op_y[1]),
        .alu_result(alu_result[1]), .alu_overflow(alu_overflow[1]),
        .alu_op_y_zero(alu_op_y_zero[1]),
        .busy(busy[1]), .contention_cnt(cnt_b)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0: w = 32'd0;
            1: w = 32'h7FFF_FFFF;
            2: w = 32'h8000_0000;
            3: w = 32'hFFFF_FFFF;
            4: w = 32'($urandom_range(0, 40));
            default: w = $urandom();
        endcase
        return w;
    endfunction

    function automatic bit want_new(input int p);
        case (mode)
            M_CONT:  return 1'b1;
            M_RAND:  return $urandom_range(0, 9) < 6;
            M_BP:    return p == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ready_val(input int p);
        case (mode)
            M_RAND:  return $urandom_range(0, 9) < 6;
            M_BP:    return p != 0;
            default: return 1'b1;
        endcase
    endfunction

    // Reference model: evaluate one cycle from the arbitration rules
    task automatic model_eval(input int d, input logic r);
        logic [1:0]  fr, el, eg;
        logic [33:0] a;
        bit          any_busy;
        sb_t         e;
        any_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            fr[p] = !infl[d][p] && (!rsv[d][p] || rs_ready[d][p]);
            any_busy |= infl[d][p] | rsv[d][p];
        end
        el = rq_valid[d] & fr;
        if (r) eg = 2'b00;
        else if (el == 2'b11) eg = (d == 0 && ptr[d]) ? 2'b10 : 2'b01;
        else eg = el;
        chk($sformatf("grant[d%0d]", d), 64'(rq_ready[d]), 64'(eg));
        chk($sformatf("contention_cnt[d%0d]", d), (d == 0) ? 64'(cnt_a) : 64'(cnt_b), 64'(cnt_m[d]));
        chk($sformatf("busy[d%0d]", d), 64'(busy[d]), 64'(any_busy));
        if (r) begin
            for (int p = 0; p < 2; p++) begin
                infl[d][p] = 1'b0;
                rsv[d][p]  = 1'b0;
                sq[2*d+p].delete();
            end
            ptr[d]   = 1'b0;
            cnt_m[d] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (eg[p]) begin
                    a = ref_alu(rq_opcode[d][p], rq_x[d][p], rq_y[d][p]);
                    e.res = a[31:0]; e.ov = a[32]; e.yz = a[33];
                    e.exp_cyc = cyc + 2; e.seen = 1'b0;
                    sq[2*d+p].push_back(e);
                    hv[d][p] = 1'b0;
                end
                rsv[d][p]  = infl[d][p] || (rsv[d][p] && !rs_ready[d][p]);
                infl[d][p] = eg[p];
            end
            if (el == 2'b11) begin
                if (d == 0) ptr[d] = !ptr[d];
                if (cnt_m[d] < ((d == 0) ? 32'd65535 : 32'd15)) cnt_m[d]++;
            end
        end
    endtask

    // One clock: drive after the edge, evaluate the model after the monitor
    task automatic step(input logic r);
        @(posedge clk);
        #1;
        rst = r;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (!hv[d][p] && want_new(p)) begin
                    hv[d][p]   = 1'b1;
                    h_op[d][p] = 5'($urandom_range(0, 9));
                    h_x[d][p]  = rand_word();
                    h_y[d][p]  = rand_word();
                end
                rq_valid[d][p]  = hv[d][p];
                rq_opcode[d][p] = h_op[d][p];
                rq_x[d][p]      = h_x[d][p];
                rq_y[d][p]      = h_y[d][p];
                rs_ready[d][p]  = ready_val(p);
            end
        end
        @(negedge clk);
        #1;
        model_eval(0, r);
        model_eval(1, r);
    endtask

    task automatic hold_op(input int p, input logic [4:0] op, input logic [31:0] x,
                           input logic [31:0] y);
        for (int d = 0; d < 2; d++) begin
            hv[d][p] = 1'b1; h_op[d][p] = op; h_x[d][p] = x; h_y[d][p] = y;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s rs_valid[d%0d]", tag, d), 64'(rs_valid[d]), 64'd0);
            chk($sformatf("%s rs_result[d%0d]", tag, d), 64'(rs_result[d]), 64'd0);
            chk($sformatf("%s rs_flags[d%0d]", tag, d), 64'({rs_overflow[d], rs_y_zero[d]}), 64'd0);
            chk($sformatf("%s alu_in[d%0d]", tag, d),
                64'({alu_opcode[d], alu_op_x[d] | alu_op_y[d]}), 64'd0);
        end
    endtask

    // Response monitor: compare every presented response with the scoreboard
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                int d, p;
                d = k / 2;
                p = k % 2;
                if (rs_valid[d][p]) begin
                    if (sq[k].size() == 0) begin
                        chk($sformatf("rs_valid unexpected[d%0d p%0d]", d, p), 64'(rs_valid[d][p]), 64'd0);
                    end else begin
                        e = sq[k].pop_front();
                        if (!e.seen) begin
                            chk($sformatf("latency[d%0d p%0d]", d, p), 64'(cyc), 64'(e.exp_cyc));
                            e.seen = 1'b1;
                        end
                        chk($sformatf("rs_result[d%0d p%0d]", d, p), 64'(rs_result[d][p]), 64'(e.res));
                        chk($sformatf("rs_overflow[d%0d p%0d]", d, p), 64'(rs_overflow[d][p]), 64'(e.ov));
                        chk($sformatf("rs_y_zero[d%0d p%0d]", d, p), 64'(rs_y_zero[d][p]), 64'(e.yz));
                        if (!rs_ready[d][p]) sq[k].push_front(e);
                    end
                end else if (sq[k].size() > 0 && sq[k][0].exp_cyc <= cyc) begin
                    chk($sformatf("rs_valid missing[d%0d p%0d]", d, p), 64'(rs_valid[d][p]), 64'd1);
                end
            end
        end
    end

    // Main stimulus sequence
    initial begin
        for (int d = 0; d < 2; d++) begin
            rq_valid[d] = 2'b00; rq_opcode[d] = '0; rq_x[d] = '0; rq_y[d] = '0;
            rs_ready[d] = 2'b11; ptr[d] = 1'b0; cnt_m[d] = 0;
            for (int p = 0; p < 2; p++) begin
                hv[d][p] = 1'b0; h_op[d][p] = '0; h_x[d][p] = '0; h_y[d][p] = '0;
                infl[d][p] = 1'b0; rsv[d][p] = 1'b0;
            end
        end

        // reset state, including rq_ready held low while a request is pending
        step(1'b1);
        hold_op(0, 5'd0, 32'd1, 32'd2);
        step(1'b1);
        check_zero("reset");
        hv[0][0] = 1'b0; hv[1][0] = 1'b0;

        // single ADD on port 0
        hold_op(0, 5'd0, 32'd5, 32'd7);
        step(1'b0); step(1'b0); step(1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("add5+7 valid[d%0d]", d), 64'(rs_valid[d][0]), 64'd1);
            chk($sformatf("add5+7 result[d%0d]", d), 64'(rs_result[d][0]), 64'd12);
            chk($sformatf("add5+7 ovf[d%0d]", d), 64'(rs_overflow[d][0]), 64'd0);
        end

        // signed overflow and Y-zero on port 1
        hold_op(1, 5'd0, 32'h7FFF_FFFF, 32'd1);
        step(1'b0); step(1'b0); step(1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ovf result[d%0d]", d), 64'(rs_result[d][1]), 64'h8000_0000);
            chk($sformatf("ovf flag[d%0d]", d), 64'(rs_overflow[d][1]), 64'd1);
        end
        hold_op(1, 5'd1, 32'd0, 32'd0);
        step(1'b0); step(1'b0); step(1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("sub0 y_zero[d%0d]", d), 64'(rs_y_zero[d][1]), 64'd1);
        end

        // continuous contention, then backpressure on port 0, then random
        mode = M_CONT; repeat (30) step(1'b0);
        mode = M_IDLE; repeat (4) step(1'b0);
        mode = M_BP;   repeat (10) step(1'b0);
        mode = M_RAND; repeat (1500) step(1'b0);
        mode = M_IDLE; repeat (8) step(1'b0);

        // reset the cycle after a contended accept that moved the pointer
        hold_op(0, 5'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        hold_op(1, 5'd3, 32'h1234_5678, 32'h0000_0001);
        step(1'b0);
        hold_op(0, 5'd4, 32'hAAAA_AAAA, 32'h5555_5555);
        step(1'b1);
        step(1'b0);
        check_zero("post-reset");
        chk("ptr after reset grant[d0]", 64'(rq_ready[0]), 64'd1);

        mode = M_CONT; repeat (12) step(1'b0);
        mode = M_IDLE; repeat (8) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational MIPS ALU (5-bit opcode, 32-bit X/Y, result/overflow/Y-zero) between two requesters, e.g. the CPU execute stage (port 0) and an accelerator/coprocessor (port 1).
- Arbitrates at one issue per cycle and registers operands into a single issue stage that drives the ALU.
- Captures each ALU result into a per-requester response buffer with a valid/ready handshake.
- Keeps a saturating contention counter for performance analysis.

Parameters:
- FAIR, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- CNT_W, 16: width of the saturating contention counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rq_valid[i]  in  1  (i=0,1) request valid.
- rq_ready[i]  out  1  request accepted this cycle when high together with rq_valid[i].
- rq_opcode[i]  in  5  ALU opcode, passed through undecoded.
- rq_x[i], rq_y[i]  in  32  ALU operands X and Y; for shifts, Y is shifted by X[4:0].
- rs_valid[i]  out  1  response valid.
- rs_ready[i]  in  1  response consumed when high with rs_valid[i].
- rs_result[i]  out  32  captured ALU result.
- rs_overflow[i]  out  1  captured ALU overflow flag.
- rs_y_zero[i]  out  1  captured ALU Y-zero flag.
- alu_opcode  out  5  to the ALU, from the issue register.
- alu_op_x, alu_op_y  out  32  to the ALU, from the issue register.
- alu_result  in  32  from the ALU.
- alu_overflow, alu_op_y_zero  in  1  from the ALU.
- busy  out  1  issue stage valid OR any rs_valid.
- contention_cnt  out  CNT_W  cycles where both ports were eligible.

Behaviour:
- Reset (rst=1 at an edge):
  - issue valid=0; rs_valid[0..1]=0; rs_result, rs_overflow, rs_y_zero=0.
  - alu_opcode, alu_op_x, alu_op_y=0; round-robin pointer=port 0; contention_cnt=0.
  - Reset aborts any in-flight op; its result is never delivered.
  - rq_ready is 0 while rst=1.
- Per-port state: inflight[i] = issue stage valid with owner i.
- Slot free: free[i] = !inflight[i] & (!rs_valid[i] | rs_ready[i]).
  - This gives a same-cycle drain bypass: a port can issue the cycle its buffer is being drained.
- Eligibility: elig[i] = rq_valid[i] & free[i].
- Grant:
  - Only one eligible: that port wins.
  - Both eligible, FAIR=1: the port the pointer names wins; pointer then moves to the other port.
  - Both eligible, FAIR=0: port 0 always wins.
  - Pointer updates only on contended grants.
  - rq_ready[i] = grant[i], combinational from rq_valid/free; requesters must not make rq_valid depend on rq_ready.
- Issue, edge ending cycle N with an accept:
  - Register owner, opcode, x, y; issue valid=1 during N+1.
  - The ALU sees the operands in cycle N+1.
  - With no accept, issue valid=0 and the ALU input registers hold their last values.
- Capture, edge ending N+1:
  - If issue valid, the owner's rs_result/rs_overflow/rs_y_zero load from the ALU outputs.
  - rs_valid[owner]=1 from cycle N+2.
  - Accept-to-rs_valid latency = 2 cycles.
- Response hold:
  - rs_* are stable while rs_valid & !rs_ready.
  - rs_valid clears on handshake unless a capture for the same port occurs on that edge; capture wins and rs_valid stays 1 with new data.
- Throughput:
  - Aggregate: one issue per cycle.
  - Per port: one issue per 2 cycles, since inflight blocks back-to-back issue on the same port.
- Flags: overflow is a reported flag only; no trap and no result suppression.
- Unknown opcodes: passed through; the result is whatever the ALU yields, and the block does not check it.
- contention_cnt: +1 on every cycle with elig[0]&elig[1]; saturates at all-ones with no wrap.
- Simultaneous accept and capture on different ports are independent and both occur.

Test Plan:
- Single op: port0 ADD x=5 y=7, rs_ready=1 → rq_ready[0]=1 same cycle; rs_valid[0]=1 two cycles later with result=12, overflow=0.
- Overflow: port1 ADD x=0x7FFFFFFF y=1 → rs_result[1]=0x80000000, rs_overflow[1]=1; SUB x=0 y=0 → rs_y_zero=1.
- Contention, FAIR=1: both ports hold valid continuously with distinct ops, rs_ready=1 → grants alternate 0,1,0,1; each port gets one response every 2 cycles; contention_cnt increments each contended cycle.
- FAIR=0: same stimulus → port 0 wins every contended cycle; port 1 is granted only in cycles where port 0 is ineligible (inflight).
- Backpressure: rs_ready[0]=0 after a response, port0 issues again → rq_ready[0]=0 until rs_ready[0]=1; in that drain cycle rq_ready[0]=1 (bypass); the old result is held unchanged meanwhile.
- Reset mid-flight: assert rst the cycle after an accept → no rs_valid next cycle; all outputs 0; pointer back to port 0; contention_cnt=0.
